// File: rtl/fifo_rd_burst_arb.sv
// fifo_rd_burst_arb
// Read-side burst arbiter that shares one async FIFO read port among NREQ
// consumers. It lives in the read clock domain next to the FIFO read pointer
// logic. Whole bursts are granted round-robin. The FIFO is only strobed while
// it is non-empty, and every returned word is steered to the granted consumer
// with a one-hot valid and a last-word flag.
//
// Ports:
//   rd_clk      read-domain clock, everything on the rising edge
//   rd_rst_n    asynchronous active-low reset
//   req         per-requester burst request (level, held until granted)
//   req_len     per-requester burst length minus one, requester i at
//               [i*BLEN_W +: BLEN_W]
//   fifo_empty  FIFO empty flag (read domain)
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read strobe
//   gnt         one-hot grant, held for the whole burst
//   out_data    returned word (straight from fifo_rdata)
//   out_valid   one-hot word-valid to the granted requester
//   out_last    marks the final word of a burst
//   busy        high whenever the arbiter is not idle
module fifo_rd_burst_arb #(
    parameter int DSIZE  = 8,
    parameter int NREQ   = 4,
    parameter int BLEN_W = 4
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BLEN_W-1:0]   req_len,
    input  logic                     fifo_empty,
    input  logic [DSIZE-1:0]         fifo_rdata,
    output logic                     fifo_rd_en,
    output logic [NREQ-1:0]          gnt,
    output logic [DSIZE-1:0]         out_data,
    output logic [NREQ-1:0]          out_valid,
    output logic                     out_last,
    output logic                     busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [BLEN_W:0] REM_ONE = (BLEN_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr, ptr_nxt;
    logic [PTR_W-1:0]    win, win_nxt;
    logic [NREQ-1:0]     gnt_nxt;
    // One bit wider than the length field so a full 2^BLEN_W burst fits
    // without wrapping.
    logic [BLEN_W:0]     rem, rem_nxt;
    logic                rd_en_d, last_d;

    logic                pick_found;
    logic [PTR_W-1:0]    pick, idx;
    logic [NREQ-1:0]     pick_onehot;
    logic [BLEN_W-1:0]   pick_len;

    // Round-robin search: walk the requesters starting at ptr and wrapping,
    // the first active one wins. The winner's one-hot grant and length field
    // are selected with constant indices so no wide index expressions appear.
    always_comb begin
        pick_found  = 1'b0;
        pick        = '0;
        idx         = '0;
        pick_onehot = '0;
        pick_len    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PTR_W'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_len       = req_len[i*BLEN_W +: BLEN_W];
            end
        end
    end

    // Reads only happen inside a burst, while words remain and the FIFO has
    // data; an empty FIFO simply stalls the burst with rem held.
    assign fifo_rd_en = (state == BURST) && !fifo_empty && (rem != '0);

    // Next-state logic. Requests and lengths are only looked at in IDLE, so a
    // requester dropping req mid-burst cannot cut the burst short. The pointer
    // moves past the winner only once its burst has fully drained, which is
    // what keeps a continuously-requesting consumer from being re-granted
    // ahead of the others.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        gnt_nxt   = gnt;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BURST;
                    win_nxt   = pick;
                    gnt_nxt   = pick_onehot;
                    rem_nxt   = {1'b0, pick_len} + REM_ONE;
                end
            end
            BURST: begin
                if (fifo_rd_en) begin
                    rem_nxt = rem - REM_ONE;
                    if (rem == REM_ONE) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                ptr_nxt   = (win == PTR_LAST) ? '0 : win + PTR_W'(1);
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                rem_nxt   = '0;
            end
        endcase
    end

    // State register plus the one-cycle delayed read strobe and last flag
    // that line up with fifo_rdata coming back from the FIFO.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            gnt     <= '0;
            rem     <= '0;
            rd_en_d <= 1'b0;
            last_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            gnt     <= gnt_nxt;
            rem     <= rem_nxt;
            rd_en_d <= fifo_rd_en;
            last_d  <= fifo_rd_en && (rem == REM_ONE);
        end
    end

    // gnt is still held during DRAIN, so the final word is steered correctly.
    assign out_data  = fifo_rdata;
    assign out_valid = gnt & {NREQ{rd_en_d}};
    assign out_last  = last_d;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_rd_burst_arb.sv
// tb_fifo_rd_burst_arb
// Self-checking bench for fifo_rd_burst_arb. A queue-like FIFO model feeds the
// arbiter; a negedge monitor logs reads, returned words and grants; each test
// task compares those logs against a round-robin reference model.
module tb_fifo_rd_burst_arb;

    localparam int DSIZE  = 8;
    localparam int NREQ   = 4;
    localparam int BLEN_W = 4;
    localparam int MEMD   = 4096;
    localparam int GNTD   = 256;

    logic                   rd_clk = 1'b0;
    logic                   rd_rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*BLEN_W-1:0] req_len;
    logic                   fifo_empty;
    logic [DSIZE-1:0]       fifo_rdata = '0;
    logic                   fifo_rd_en;
    logic [NREQ-1:0]        gnt;
    logic [DSIZE-1:0]       out_data;
    logic [NREQ-1:0]        out_valid;
    logic                   out_last;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    int ptr_model = 0;

    fifo_rd_burst_arb #(
        .DSIZE  (DSIZE),
        .NREQ   (NREQ),
        .BLEN_W (BLEN_W)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .req        (req),
        .req_len    (req_len),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .gnt        (gnt),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: words written by the tests, popped in order on each read.
    logic [DSIZE-1:0] fifo_mem [MEMD];
    int  push_total = 0;
    int  pop_total  = 0;
    logic flush_req = 1'b0;

    assign fifo_empty = (push_total == pop_total);

    always @(posedge rd_clk) begin
        if (flush_req) begin
            pop_total <= push_total;
        end else if (fifo_rd_en) begin
            fifo_rdata <= fifo_mem[pop_total % MEMD];
            pop_total  <= pop_total + 1;
        end
    end

    // Monitor: samples mid-cycle and logs every read, returned word and grant.
    int cyc = 0;
    int n_rd = 0, n_val = 0, n_gnt = 0, n_rd_empty = 0, n_stray_last = 0;
    int busy_fall_cyc = 0;
    int rd_cyc  [MEMD];
    int val_cyc [MEMD];
    logic [NREQ-1:0]  val_vec  [MEMD];
    logic [DSIZE-1:0] val_data [MEMD];
    logic             val_last [MEMD];
    logic [NREQ-1:0]  gnt_vec  [GNTD];
    int               gnt_cyc  [GNTD];
    logic [NREQ-1:0]  prev_gnt  = '0;
    logic             prev_busy = 1'b0;

    always @(negedge rd_clk) begin
        cyc       <= cyc + 1;
        prev_gnt  <= gnt;
        prev_busy <= busy;
        if (fifo_rd_en) begin
            rd_cyc[n_rd % MEMD] <= cyc;
            n_rd <= n_rd + 1;
            if (fifo_empty) n_rd_empty <= n_rd_empty + 1;
        end
        if (out_valid != '0) begin
            val_cyc[n_val % MEMD]  <= cyc;
            val_vec[n_val % MEMD]  <= out_valid;
            val_data[n_val % MEMD] <= out_data;
            val_last[n_val % MEMD] <= out_last;
            n_val <= n_val + 1;
        end else if (out_last) begin
            n_stray_last <= n_stray_last + 1;
        end
        if (gnt != '0 && gnt != prev_gnt) begin
            gnt_vec[n_gnt % GNTD] <= gnt;
            gnt_cyc[n_gnt % GNTD] <= cyc;
            n_gnt <= n_gnt + 1;
        end
        if (prev_busy && !busy) busy_fall_cyc <= cyc;
    end

    // Reference model helpers: round-robin pick from a pointer, and one-hot.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (((r >> ((p + k) % NREQ)) & NREQ'(1)) != '0) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[push_total % MEMD] = DSIZE'($urandom);
            push_total++;
        end
    endtask

    task automatic flush_fifo();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*BLEN_W +: BLEN_W] = BLEN_W'(v);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            step();
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0;
        req      = '0;
        req_len  = '0;
        repeat (3) step();
        push_words(4);
        step();
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        checks++; if (gnt !== '0) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (out_valid !== '0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0000", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rd_rst_n = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req: got busy=%b rd_en=%b expected 0/0", busy, fifo_rd_en); end
        ptr_model = 0;
    endtask

    task automatic test_single_burst();
        bit ok;
        int rb, vb, gb, base_w, w;
        flush_fifo();
        push_words(10);
        base_w = pop_total; rb = n_rd; vb = n_val; gb = n_gnt;
        w = rr_pick(4'b0001, ptr_model);
        req_len = '0; set_len(0, 3);
        req = 4'b0001;
        wait_gnt(ok);
        req = '0;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_grant_timeout: got no grant expected %b", onehot(w)); end
        checks++; if (gnt !== onehot(w) || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_gnt: got gnt=%b busy=%b expected %b/1", gnt, busy, onehot(w)); end
        wait_idle(ok);
        step();
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_idle_timeout: got busy=%b expected 0", busy); end
        checks++; if (n_rd - rb != 4) begin errors++; $display("[TB] FAIL single_reads: got %0d expected 4", n_rd - rb); end
        checks++; if (n_val - vb != 4) begin errors++; $display("[TB] FAIL single_valids: got %0d expected 4", n_val - vb); end
        checks++; if (rd_cyc[rb % MEMD] != gnt_cyc[gb % GNTD]) begin errors++; $display("[TB] FAIL single_first_read: got cycle %0d expected %0d", rd_cyc[rb % MEMD], gnt_cyc[gb % GNTD]); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (val_cyc[(vb+i) % MEMD] != rd_cyc[rb % MEMD] + 1 + i || val_vec[(vb+i) % MEMD] !== onehot(w)
                || val_data[(vb+i) % MEMD] !== fifo_mem[(base_w+i) % MEMD] || val_last[(vb+i) % MEMD] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL single_word%0d: got cyc=%0d vld=%b data=%h last=%b expected cyc=%0d vld=%b data=%h last=%b", i,
                         val_cyc[(vb+i) % MEMD], val_vec[(vb+i) % MEMD], val_data[(vb+i) % MEMD], val_last[(vb+i) % MEMD],
                         rd_cyc[rb % MEMD] + 1 + i, onehot(w), fifo_mem[(base_w+i) % MEMD], (i == 3));
            end
        end
        checks++; if (busy_fall_cyc != rd_cyc[(rb+3) % MEMD] + 2) begin errors++; $display("[TB] FAIL single_busy_drop: got cycle %0d expected %0d", busy_fall_cyc, rd_cyc[(rb+3) % MEMD] + 2); end
        ptr_model = (w + 1) % NREQ;
    endtask

    task automatic test_round_robin();
        bit ok;
        int rb, vb, gb, t, w;
        rd_rst_n = 1'b0;
        step();
        rd_rst_n = 1'b1;
        ptr_model = 0;
        flush_fifo();
        push_words(8);
        rb = n_rd; vb = n_val; gb = n_gnt;
        req_len = '0;
        req = 4'b1111;
        t = 0;
        while (n_gnt - gb < 5 && t < 100) begin step(); t++; end
        req = '0;
        checks++; if (n_gnt - gb < 5) begin errors++; $display("[TB] FAIL rr_timeout: got %0d grants expected 5", n_gnt - gb); end
        wait_idle(ok);
        step();
        checks++; if (n_rd - rb != 5 || n_val - vb != 5) begin errors++; $display("[TB] FAIL rr_counts: got reads=%0d valids=%0d expected 5/5", n_rd - rb, n_val - vb); end
        for (int i = 0; i < 5; i++) begin
            w = rr_pick(4'b1111, ptr_model);
            checks++;
            if (gnt_vec[(gb+i) % GNTD] !== onehot(w) || val_vec[(vb+i) % MEMD] !== onehot(w) || val_last[(vb+i) % MEMD] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got gnt=%b vld=%b last=%b expected %b/%b/1", i, gnt_vec[(gb+i) % GNTD], val_vec[(vb+i) % MEMD], val_last[(vb+i) % MEMD], onehot(w), onehot(w));
            end
            ptr_model = (w + 1) % NREQ;
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (rd_cyc[(rb+i) % MEMD] - rd_cyc[(rb+i-1) % MEMD] != 3) begin
                errors++;
                $display("[TB] FAIL rr_spacing%0d: got %0d expected 3", i, rd_cyc[(rb+i) % MEMD] - rd_cyc[(rb+i-1) % MEMD]);
            end
        end
    endtask

    task automatic test_empty_stall();
        bit ok;
        int rb, vb, base_w, w;
        flush_fifo();
        push_words(3);
        base_w = pop_total; rb = n_rd; vb = n_val;
        w = rr_pick(4'b0100, ptr_model);
        req_len = '0; set_len(2, 7);
        req = 4'b0100;
        wait_gnt(ok);
        req = '0;
        checks++; if (gnt !== onehot(w)) begin errors++; $display("[TB] FAIL stall_gnt: got %b expected %b", gnt, onehot(w)); end
        for (int t = 0; t < 20 && !fifo_empty; t++) step();
        repeat (5) step();
        push_words(5);
        wait_idle(ok);
        step();
        checks++; if (n_rd - rb != 8) begin errors++; $display("[TB] FAIL stall_reads: got %0d expected 8", n_rd - rb); end
        checks++; if (rd_cyc[(rb+3) % MEMD] - rd_cyc[(rb+2) % MEMD] != 6) begin errors++; $display("[TB] FAIL stall_gap: got %0d expected 6", rd_cyc[(rb+3) % MEMD] - rd_cyc[(rb+2) % MEMD]); end
        checks++; if (n_val - vb != 8) begin errors++; $display("[TB] FAIL stall_valids: got %0d expected 8", n_val - vb); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (val_cyc[(vb+i) % MEMD] != rd_cyc[(rb+i) % MEMD] + 1 || val_vec[(vb+i) % MEMD] !== onehot(w)
                || val_data[(vb+i) % MEMD] !== fifo_mem[(base_w+i) % MEMD] || val_last[(vb+i) % MEMD] !== (i == 7)) begin
                errors++;
                $display("[TB] FAIL stall_word%0d: got cyc=%0d vld=%b data=%h last=%b expected cyc=%0d vld=%b data=%h last=%b", i,
                         val_cyc[(vb+i) % MEMD], val_vec[(vb+i) % MEMD], val_data[(vb+i) % MEMD], val_last[(vb+i) % MEMD],
                         rd_cyc[(rb+i) % MEMD] + 1, onehot(w), fifo_mem[(base_w+i) % MEMD], (i == 7));
            end
        end
        ptr_model = (w + 1) % NREQ;
    endtask

    task automatic test_max_burst();
        bit ok;
        int rb, vb, gb, base_w, r, w, last_cnt;
        flush_fifo();
        push_words(20);
        base_w = pop_total; rb = n_rd; vb = n_val; gb = n_gnt;
        r = int'($urandom_range(0, NREQ - 1));
        w = rr_pick(onehot(r), ptr_model);
        req_len = '0; set_len(r, 15);
        req = onehot(r);
        wait_gnt(ok);
        req = '0;
        wait_idle(ok);
        step();
        checks++; if (gnt_vec[gb % GNTD] !== onehot(w)) begin errors++; $display("[TB] FAIL max_gnt: got %b expected %b", gnt_vec[gb % GNTD], onehot(w)); end
        checks++; if (n_rd - rb != 16) begin errors++; $display("[TB] FAIL max_reads: got %0d expected 16", n_rd - rb); end
        checks++; if (n_val - vb != 16) begin errors++; $display("[TB] FAIL max_valids: got %0d expected 16", n_val - vb); end
        last_cnt = 0;
        for (int i = 0; i < 16; i++) if (val_last[(vb+i) % MEMD]) last_cnt++;
        checks++; if (val_last[(vb+15) % MEMD] !== 1'b1 || last_cnt != 1) begin errors++; $display("[TB] FAIL max_last: got last16=%b count=%0d expected 1/1", val_last[(vb+15) % MEMD], last_cnt); end
        checks++; if (val_data[(vb+15) % MEMD] !== fifo_mem[(base_w+15) % MEMD]) begin errors++; $display("[TB] FAIL max_data: got %h expected %h", val_data[(vb+15) % MEMD], fifo_mem[(base_w+15) % MEMD]); end
        ptr_model = (w + 1) % NREQ;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int cnt;
        flush_fifo();
        push_words(10);
        req_len = '0; set_len(1, 5);
        req = 4'b0010;
        wait_gnt(ok);
        req = '0;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (fifo_rd_en) cnt++;
            if (cnt == 3) break;
            step();
        end
        checks++; if (cnt != 3) begin errors++; $display("[TB] FAIL rstmid_reach: got %0d reads expected 3", cnt); end
        rd_rst_n = 1'b0;
        #1;
        checks++; if (fifo_rd_en !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ctrl: got rd_en=%b gnt=%b busy=%b expected 0/0000/0", fifo_rd_en, gnt, busy); end
        checks++; if (out_valid !== '0 || out_last !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out: got vld=%b last=%b expected 0000/0", out_valid, out_last); end
        step();
        step();
        req_len = BLEN_W*NREQ'($urandom);
        req = 4'b1001;
        rd_rst_n = 1'b1;
        ptr_model = 0;
        wait_gnt(ok);
        req = '0;
        checks++; if (gnt !== onehot(rr_pick(4'b1001, ptr_model))) begin errors++; $display("[TB] FAIL rstmid_regrant: got %b expected %b", gnt, onehot(rr_pick(4'b1001, ptr_model))); end
        ptr_model = (rr_pick(4'b1001, ptr_model) + 1) % NREQ;
        wait_idle(ok);
        step();
    endtask

    task automatic test_drop_req();
        bit ok;
        int vb, gb, w1, w2, l3, c1, c3;
        flush_fifo();
        push_words(24);
        vb = n_val; gb = n_gnt;
        l3 = int'($urandom_range(0, 15));
        req_len = '0; set_len(1, 5); set_len(3, l3);
        req = 4'b1010;
        w1 = rr_pick(4'b1010, ptr_model);
        wait_gnt(ok);
        req = 4'b1000;
        checks++; if (gnt !== onehot(w1)) begin errors++; $display("[TB] FAIL drop_gnt1: got %b expected %b", gnt, onehot(w1)); end
        w2 = rr_pick(4'b1000, (w1 + 1) % NREQ);
        for (int t = 0; t < 80 && n_gnt - gb < 2; t++) step();
        req = '0;
        wait_idle(ok);
        repeat (6) step();
        checks++; if (n_gnt - gb != 2) begin errors++; $display("[TB] FAIL drop_grant_count: got %0d expected 2", n_gnt - gb); end
        checks++; if (gnt_vec[(gb+1) % GNTD] !== onehot(w2)) begin errors++; $display("[TB] FAIL drop_gnt2: got %b expected %b", gnt_vec[(gb+1) % GNTD], onehot(w2)); end
        c1 = 0; c3 = 0;
        for (int i = vb; i < n_val; i++) begin
            if (val_vec[i % MEMD] === onehot(w1)) c1++;
            if (val_vec[i % MEMD] === onehot(w2)) c3++;
        end
        checks++; if (c1 != 6) begin errors++; $display("[TB] FAIL drop_words_req1: got %0d expected 6", c1); end
        checks++; if (c3 != l3 + 1) begin errors++; $display("[TB] FAIL drop_words_req3: got %0d expected %0d", c3, l3 + 1); end
        ptr_model = (w2 + 1) % NREQ;
    endtask

    task automatic test_random();
        bit done;
        int rb, vb, gb, base_w, w, nw, empty0, stray0;
        logic [NREQ-1:0] r;
        empty0 = n_rd_empty; stray0 = n_stray_last;
        for (int b = 0; b < 25; b++) begin
            base_w = pop_total; rb = n_rd; vb = n_val; gb = n_gnt;
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_len = (NREQ*BLEN_W)'($urandom);
            w = rr_pick(r, ptr_model);
            nw = int'(req_len[w*BLEN_W +: BLEN_W]) + 1;
            req = r;
            done = 1'b0;
            for (int t = 0; t < 300; t++) begin
                if ($urandom_range(0, 2) != 0) push_words(1);
                step();
                if (gnt != '0) req = '0;
                if (req == '0 && busy == 1'b0) begin done = 1'b1; break; end
            end
            req = '0;
            step();
            checks++; if (!done) begin errors++; $display("[TB] FAIL rand%0d_timeout: got busy=%b expected 0", b, busy); end
            checks++; if (n_gnt - gb != 1 || gnt_vec[gb % GNTD] !== onehot(w)) begin errors++; $display("[TB] FAIL rand%0d_gnt: got %b (%0d grants) expected %b", b, gnt_vec[gb % GNTD], n_gnt - gb, onehot(w)); end
            checks++; if (n_val - vb != nw || n_rd - rb != nw) begin errors++; $display("[TB] FAIL rand%0d_count: got valids=%0d reads=%0d expected %0d", b, n_val - vb, n_rd - rb, nw); end
            for (int i = 0; i < nw; i++) begin
                checks++;
                if (val_vec[(vb+i) % MEMD] !== onehot(w) || val_data[(vb+i) % MEMD] !== fifo_mem[(base_w+i) % MEMD]
                    || val_last[(vb+i) % MEMD] !== (i == nw - 1) || val_cyc[(vb+i) % MEMD] != rd_cyc[(rb+i) % MEMD] + 1) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_word%0d: got vld=%b data=%h last=%b expected %b/%h/%b", b, i,
                             val_vec[(vb+i) % MEMD], val_data[(vb+i) % MEMD], val_last[(vb+i) % MEMD],
                             onehot(w), fifo_mem[(base_w+i) % MEMD], (i == nw - 1));
                end
            end
            ptr_model = (w + 1) % NREQ;
        end
        checks++; if (n_rd_empty != empty0) begin errors++; $display("[TB] FAIL rand_read_while_empty: got %0d expected 0", n_rd_empty - empty0); end
        checks++; if (n_stray_last != stray0) begin errors++; $display("[TB] FAIL rand_stray_last: got %0d expected 0", n_stray_last - stray0); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_empty_stall();
        test_max_burst();
        test_reset_mid_burst();
        test_drop_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
